// File: rtl/naes_pkg.sv
// Shared constants for the controller port: button bit positions, the open-bus
// upper bits returned on $4016/$4017 reads, and the default turbo divider.
package naes_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [6:0] OPEN_BUS = 7'b0100000;

  // About 15 Hz autofire at 50 MHz.
  localparam int unsigned TURBO_DIV_DEFAULT = 1666667;

  function automatic logic [7:0] read_byte(input logic bit0);
    return {OPEN_BUS, bit0};
  endfunction

endpackage

// File: rtl/controller_port_if.sv
// CPU-side bus view of the controller port: access strobe, decode hits,
// write data and the two read-data bytes.
interface controller_port_if;
  logic       cpu_ce;
  logic       cpu_wr;
  logic       control1_en;
  logic       control2_en;
  logic [7:0] cpu_do;
  logic [7:0] control1;
  logic [7:0] control2;

  modport master (
    output cpu_ce, cpu_wr, control1_en, control2_en, cpu_do,
    input  control1, control2
  );

  modport slave (
    input  cpu_ce, cpu_wr, control1_en, control2_en, cpu_do,
    output control1, control2
  );
endinterface

// File: rtl/pad_shifter.sv
// One joypad: 2-flop button synchroniser feeding an 8-bit parallel-load
// shift register that shifts right and fills with 1.
module pad_shifter
  import naes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn,
  input  logic [1:0] force_ab,
  input  logic       load,
  input  logic       shift,
  output logic       data
);

  logic [7:0] sync1_q, sync2_q, sr_q;
  logic [7:0] load_val;

  // force_ab is already synchronous (turbo), so it is ORed after the synchroniser.
  always_comb begin
    load_val        = sync2_q;
    load_val[BTN_A] = sync2_q[BTN_A] | force_ab[0];
    load_val[BTN_B] = sync2_q[BTN_B] | force_ab[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      sr_q    <= 8'hFF;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (load) begin
        sr_q <= load_val;
      end else if (shift) begin
        sr_q <= {1'b1, sr_q[7:1]};
      end
    end
  end

  assign data = sr_q[0];

endmodule

// File: rtl/controller_port.sv
// $4016/$4017 joypad port: strobe register, bus decode and read formatting.
// Optional autofire on A/B is enabled with the CONTROLLER_TURBO_EN macro.
module controller_port
  import naes_pkg::*;
`ifdef CONTROLLER_TURBO_EN
#(
  parameter int unsigned TURBO_DIV = TURBO_DIV_DEFAULT
)
`endif
(
  input logic              clk,
  input logic              reset,
  controller_port_if.slave bus,
  input logic [7:0]        pad1_btn,
  input logic [7:0]        pad2_btn
`ifdef CONTROLLER_TURBO_EN
  ,
  input logic [1:0]        pad1_turbo,
  input logic [1:0]        pad2_turbo
`endif
);

  logic strobe_q;
  logic strobe_wr;
  logic shift1, shift2;
  logic data1, data2;
  logic [1:0] force1, force2;

  // Write decode wins over any read shift; $4017 writes belong to the APU.
  assign strobe_wr = bus.cpu_ce & bus.control1_en & ~bus.cpu_wr;
  assign shift1    = bus.cpu_ce & bus.control1_en & bus.cpu_wr & ~strobe_q & ~strobe_wr;
  assign shift2    = bus.cpu_ce & bus.control2_en & bus.cpu_wr & ~strobe_q & ~strobe_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else if (strobe_wr) begin
      strobe_q <= bus.cpu_do[0];
    end
  end

`ifdef CONTROLLER_TURBO_EN
  logic [31:0] turbo_cnt_q;
  logic        phase_q;
  logic [3:0]  turbo_s1_q, turbo_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b0;
      turbo_s1_q  <= '0;
      turbo_s2_q  <= '0;
    end else begin
      turbo_s1_q <= {pad2_turbo, pad1_turbo};
      turbo_s2_q <= turbo_s1_q;
      if (turbo_cnt_q == TURBO_DIV - 1) begin
        turbo_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + 32'd1;
      end
    end
  end

  assign force1 = turbo_s2_q[1:0] & {2{phase_q}};
  assign force2 = turbo_s2_q[3:2] & {2{phase_q}};
`else
  assign force1 = 2'b00;
  assign force2 = 2'b00;
`endif

  pad_shifter u_pad1 (
    .clk      (clk),
    .reset    (reset),
    .btn      (pad1_btn),
    .force_ab (force1),
    .load     (strobe_q),
    .shift    (shift1),
    .data     (data1)
  );

  pad_shifter u_pad2 (
    .clk      (clk),
    .reset    (reset),
    .btn      (pad2_btn),
    .force_ab (force2),
    .load     (strobe_q),
    .shift    (shift2),
    .data     (data2)
  );

  assign bus.control1 = read_byte(data1);
  assign bus.control2 = read_byte(data2);

endmodule

// File: tb/tb_controller_port.sv
// Self-checking bench for controller_port: directed scenarios plus randomized
// strobe/read/reset traffic against a serial-protocol reference model.
module tb_controller_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pad1_btn, pad2_btn;
  int         checks = 0;
  int         errors = 0;

  controller_port_if bus_if ();

  always #5 clk = ~clk;

`ifdef CONTROLLER_TURBO_EN
  logic [1:0] pad1_turbo = 2'b00;
  logic [1:0] pad2_turbo = 2'b00;
  controller_port #(.TURBO_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .pad1_btn   (pad1_btn),
    .pad2_btn   (pad2_btn),
    .pad1_turbo (pad1_turbo),
    .pad2_turbo (pad2_turbo)
  );
`else
  controller_port dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .pad1_btn (pad1_btn),
    .pad2_btn (pad2_btn)
  );
`endif

  // Reference model: strobe level, byte captured at the falling strobe and
  // number of reads taken since, per pad.
  logic       m_strobe;
  logic [7:0] m_lat [2];
  int         m_idx [2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] btn_of(input int port);
    return (port == 1) ? pad1_btn : pad2_btn;
  endfunction

  task automatic bus_cycle(input logic wr, input logic e1, input logic e2, input logic [7:0] d,
                           output logic [7:0] c1, output logic [7:0] c2);
    @(negedge clk);
    bus_if.cpu_ce      = 1'b1;
    bus_if.cpu_wr      = wr;
    bus_if.control1_en = e1;
    bus_if.control2_en = e2;
    bus_if.cpu_do      = d;
    #1;
    c1 = bus_if.control1;
    c2 = bus_if.control2;
    @(posedge clk);
    #1;
    bus_if.cpu_ce      = 1'b0;
    bus_if.control1_en = 1'b0;
    bus_if.control2_en = 1'b0;
    @(posedge clk);
  endtask

  task automatic write_port(input int port, input logic [7:0] d);
    logic [7:0] c1, c2;
    bus_cycle(1'b0, port == 1, port == 2, d, c1, c2);
    if (port == 1) begin
      if (m_strobe && !d[0]) begin
        m_lat[0] = pad1_btn;
        m_lat[1] = pad2_btn;
        m_idx[0] = 0;
        m_idx[1] = 0;
      end
      m_strobe = d[0];
    end
  endtask

  task automatic read_port(input int port, input string tag);
    logic [7:0] c1, c2, got;
    logic       bit0;
    logic [7:0] lat;
    lat = m_lat[port-1];
    if (m_strobe) bit0 = btn_of(port) >> 0;
    else if (m_idx[port-1] < 8) bit0 = lat[m_idx[port-1]];
    else bit0 = 1'b1;
    bus_cycle(1'b1, port == 1, port == 2, 8'h00, c1, c2);
    got = (port == 1) ? c1 : c2;
    check(tag, got, {7'b0100000, bit0});
    if (!m_strobe) m_idx[port-1]++;
  endtask

  task automatic set_buttons(input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    pad1_btn = b1;
    pad2_btn = b2;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_c1", bus_if.control1, 8'h41);
    check("reset_c2", bus_if.control2, 8'h41);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    m_strobe = 1'b0;
    m_lat[0] = 8'hFF;
    m_lat[1] = 8'hFF;
    m_idx[0] = 0;
    m_idx[1] = 0;
  endtask

  initial begin
    reset              = 1'b1;
    pad1_btn           = 8'h00;
    pad2_btn           = 8'h00;
    bus_if.cpu_ce      = 1'b0;
    bus_if.cpu_wr      = 1'b1;
    bus_if.control1_en = 1'b0;
    bus_if.control2_en = 1'b0;
    bus_if.cpu_do      = 8'h00;
    m_strobe           = 1'b0;
    m_lat[0]           = 8'hFF;
    m_lat[1]           = 8'hFF;
    m_idx[0]           = 0;
    m_idx[1]           = 0;

    // Reset state and idle after release
    #2;
    check("por_c1", bus_if.control1, 8'h41);
    check("por_c2", bus_if.control2, 8'h41);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("idle_c1", bus_if.control1, 8'h41);
    check("idle_c2", bus_if.control2, 8'h41);

    // Latch 8'b1000_0101 and read nine times (ninth returns 1)
    set_buttons(8'b1000_0101, 8'h00);
    write_port(1, 8'h01);
    write_port(1, 8'h00);
    for (int i = 0; i < 9; i++) read_port(1, $sformatf("seq_read%0d", i + 1));

    // Strobe held high: reads track live A without shifting
    write_port(1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      set_buttons({pad1_btn[7:1], ~pad1_btn[0]}, pad2_btn);
      read_port(1, "live_a");
      read_port(1, "live_a_again");
    end
    write_port(1, 8'h00);

    // Pads shift independently
    set_buttons(8'h01, 8'h02);
    write_port(1, 8'h01);
    write_port(1, 8'h00);
    for (int i = 0; i < 3; i++) read_port(2, "pad2_read");
    read_port(1, "pad1_unshifted");

    // $4017 write leaves strobe alone; reset mid-sequence discards progress
    write_port(2, 8'h01);
    read_port(1, "after_4017_wr");
    read_port(1, "after_4017_wr2");
    do_reset();
    read_port(1, "post_reset_p1");
    read_port(2, "post_reset_p2");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      set_buttons(8'($urandom), 8'($urandom));
      write_port(1, 8'($urandom) | 8'h01);
      if ($urandom_range(0, 2) == 0) read_port(($urandom_range(0, 1) == 0) ? 1 : 2, "rnd_live");
      write_port(1, 8'($urandom) & 8'hFE);
      for (int r = 0; r < int'($urandom_range(0, 11)); r++) begin
        case ($urandom_range(0, 9))
          0: write_port(2, 8'($urandom));
          1: set_buttons(8'($urandom), 8'($urandom));
          default: read_port(($urandom_range(0, 1) == 0) ? 1 : 2, "rnd_read");
        endcase
      end
      if ($urandom_range(0, 7) == 0) do_reset();
    end

`ifdef CONTROLLER_TURBO_EN
    // Turbo A with buttons released: latched A toggles every 4 clocks
    begin
      logic s [16];
      set_buttons(8'h00, 8'h00);
      pad1_turbo = 2'b01;
      write_port(1, 8'h01);
      repeat (4) @(posedge clk);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        s[i] = bus_if.control1[0];
      end
      for (int i = 0; i < 12; i++) check("turbo_toggle", {7'd0, s[i+4]}, {7'd0, ~s[i]});
      pad1_turbo = 2'b00;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_port.md
CONTROLLER_PORT -- requirements
Module: controller_port

Interface
REQ-001 TURBO_DIV, 1666667, clock cycles per turbo phase toggle (about 15 Hz autofire at 50 MHz); used only under TURBO_EN.
REQ-002 CLK  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CPU_CE  input  1  one-clock pulse on the final clock of each CPU bus cycle.
REQ-005 CPU_WR  input  1  bus direction: 1 = CPU read, 0 = CPU write.
REQ-006 CONTROL1_EN  input  1  address decode hit for $4016.
REQ-007 CONTROL2_EN  input  1  address decode hit for $4017.
REQ-008 CPU_DO  input  8  CPU write data.
REQ-009 PAD1_BTN, PAD2_BTN  input  8 each  raw active-high buttons, asynchronous to CLK; bit order 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-010 CONTROL1, CONTROL2  output  8 each  read data for $4016/$4017, consumed by the bus mux.

Function
REQ-011 Each PADn_BTN SHALL pass through a 2-flop synchroniser before any use; button-to-latch latency is 2 clocks.
REQ-012 A strobe write occurs when CPU_CE=1, CONTROL1_EN=1 and CPU_WR=0; STROBE SHALL load CPU_DO[0] on that clock.
REQ-013 Writes with CONTROL2_EN=1 SHALL be ignored ($4017 write belongs to the APU).
REQ-014 While STROBE=1, both 8-bit shift registers SHALL reload from their synchronised buttons every clock.
REQ-015 Because of REQ-014, reloading continues on the clock after a 1->0 strobe write, so the last sample taken is the state captured at the falling strobe.
REQ-016 A read shift occurs when CPU_CE=1, CONTROLn_EN=1, CPU_WR=1 and STROBE=0; the pad n register SHALL shift right one place with 1 filled into bit 7.
REQ-017 A read while STROBE=1 SHALL NOT shift; it returns the live A bit.
REQ-018 CONTROLn SHALL equal {7'b0100000, SRn[0]}; it is registered-state driven, stable for the whole access, and updates the clock after the shift.
REQ-019 Reads 1-8 after latching SHALL return A, B, Select, Start, Up, Down, Left, Right; the 9th and later reads SHALL return bit0 = 1.
REQ-020 A strobe write and a read shift cannot occur on the same clock (one bus access per CPU_CE); if both enables are asserted, the write decode takes precedence and no shift occurs.
REQ-021 Reads to $4016 and $4017 SHALL shift only their own pad register.

Reset
REQ-022 While RESET is asserted, the block SHALL hold STROBE=0, SR1=SR2=8'hFF, synchronisers=0, turbo counter=0 and turbo phase=0.
REQ-023 While RESET is asserted, CONTROL1 and CONTROL2 SHALL read 8'h41.
REQ-024 Reset asserted in the middle of a read sequence SHALL discard all progress; the next strobe starts a fresh sequence.

Configuration
REQ-025 With `CONTROLLER_TURBO_EN` defined, the block SHALL add inputs PAD1_TURBO[1:0] and PAD2_TURBO[1:0] (bit0 = turbo A, bit1 = turbo B), plus a free-running counter.
REQ-026 Under `CONTROLLER_TURBO_EN`, the counter SHALL wrap at TURBO_DIV-1 and toggle the turbo phase on each wrap.
REQ-027 Under `CONTROLLER_TURBO_EN`, the loaded A bit SHALL be BTN[0] | (TURBO[0] & phase), and the loaded B bit SHALL be BTN[1] | (TURBO[1] & phase); TURBO inputs are synchronised like the buttons.
REQ-028 Without `CONTROLLER_TURBO_EN`, the turbo ports, counter and phase SHALL be absent and behaviour is exactly REQ-011..021.

Structure
REQ-029 Shared package naes_pkg SHALL hold: button index constants (BTN_A..BTN_RIGHT), the open-bus constant 7'b0100000, and the default TURBO_DIV.
REQ-030 Sub-module pad_shifter SHALL implement the synchroniser, shift register and load/shift control, and SHALL be instantiated twice.
REQ-031 controller_port SHALL own STROBE, write decode, turbo logic and output formatting.

Verification
REQ-032 Reset -> CONTROL1=CONTROL2=8'h41; after release with no access, both still read 8'h41.
REQ-033 PAD1_BTN=8'b1000_0101; write $4016=1 then $4016=0; nine reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1,1; each CONTROL1 value is 8'h40 or 8'h41.
REQ-034 Strobe held at 1, PAD1_BTN[0] toggled -> each $4016 read tracks the A bit 2 clocks after the change, with no shift.
REQ-035 After latching PAD1=8'h01 and PAD2=8'h02, three reads of $4017 -> 0,1,0; a following $4016 read -> 1 (pad 1 unshifted).
REQ-036 Write of 8'h01 to $4017 -> STROBE unchanged; reset asserted after 3 reads -> next reads return 1 until a re-strobe.
REQ-037 With `CONTROLLER_TURBO_EN`, TURBO_DIV=4, PAD1_TURBO=2'b01, buttons=0 -> latched A alternates 0/1 every 4 clocks.
